itof_share_arb: RTL and testbench
=================================

Name: itof_share_arb

Overview:
- Shares one pipelined int-to-float converter (32-bit signed int in, IEEE-754 single out, fixed LAT-cycle latency, no handshake) among N_REQ requesters.
- Provides round-robin issue arbitration with valid/ready request handshakes.
- Tracks each in-flight conversion's requester ID through a tag shift register.
- Buffers results in a response FIFO with credit-based flow control, so back-pressure never drops a converter result.
- Sits in the FPU between the integer-side requesters and the shared converter instance.

Parameters:
- N_REQ, 4, number of requesters.
- LAT, 3, converter latency: op sampled at the edge ending cycle c, result valid during cycle c+LAT.
- FIFO_DEPTH, 8, response FIFO entries. Must be >= LAT+2 for one issue per cycle.
- IDW, $clog2(N_REQ), requester ID width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  request valid per requester.
- req_op  in  32*N_REQ  requester i operand at [32i+31:32i].
- req_ready  out  N_REQ  one-hot accept; at most one bit high.
- conv_op  out  32  operand to converter.
- conv_result  in  32  converter result.
- resp_valid  out  1  FIFO head valid.
- resp_id  out  IDW  requester ID of head.
- resp_data  out  32  float result of head.
- resp_ready  in  1  consumer accepts head.
- busy  out  1  conversions in flight or FIFO non-empty.

Behaviour:
- Credit rule
  - issue_ok = (fifo_count + inflight) < FIFO_DEPTH, using registered values.
  - A pop in the same cycle does not free a credit until the next cycle.
- Arbitration (combinational)
  - Search req_valid starting at rr_ptr, ascending, wrapping to 0; the first set bit wins.
  - issue = issue_ok & |req_valid.
  - req_ready[g] = issue for grant g; all other bits are 0. req_ready may depend combinationally on req_valid.
  - conv_op = req_op[g] when issue, else 32'd0.
- rr_ptr
  - On an issue edge, rr_ptr <= (g+1) mod N_REQ. Otherwise it holds.
- Tag pipeline
  - LAT stages of {v, id}. Stage 0 loads {issue, g} each edge; stage k loads stage k-1.
  - Stage LAT-1 valid during cycle c+LAT marks conv_result as belonging to that ID.
  - At that edge, push {id, conv_result} into the FIFO.
- inflight
  - Count of valid tag stages, kept as a counter.
  - +1 on issue, -1 on push; unchanged when both occur in the same cycle.
- FIFO
  - Synchronous, show-ahead.
  - resp_valid = fifo_count != 0.
  - resp_id/resp_data are 0 when empty. They must stay stable while resp_valid & !resp_ready.
  - Pop on resp_valid & resp_ready.
  - Push and pop in the same cycle: count unchanged. Push on empty FIFO is visible the next cycle (no bypass).
  - Overflow is impossible by the credit rule; the assertion bench checks push never occurs with fifo_count == FIFO_DEPTH.
- Latency
  - Issue in cycle c gives resp_valid in cycle c+LAT+1 when the FIFO was empty.
  - Responses return in issue order.
- busy = (inflight != 0) | (fifo_count != 0).
- Reset
  - Asynchronous. Clears rr_ptr, all tag valids, inflight, FIFO pointers and count.
  - While reset is asserted: req_ready = 0, resp_valid = 0, resp_id = 0, resp_data = 0, busy = 0.
- Reset mid-operation
  - In-flight tags are discarded.
  - Converter results arriving after deassertion carry no valid tag and are never pushed.
  - No response is produced for requests accepted before reset.

Decomposition:
- Shared package fpu_pkg holds:
  - FP_W = 32.
  - ITOF_LAT = 3, the default for LAT.
  - A typedef for the response entry {id, data}.
- Sub-module itof_resp_fifo: parameterised sync FIFO with count output and async active-high reset.
- The arbiter, tag pipeline and credit logic stay in itof_share_arb.
- The converter is instantiated beside this block at FPU top level, not inside it.

Test Plan:
1. Single request: only req_valid[0], op 32'd1, issue cycle 0, resp_ready=1 -> resp_valid in cycle 4 only, resp_id 0, resp_data 32'h3F800000; busy high cycles 1-4.
2. All four requesters continuously valid, ops 32'hFFFFFFFF, 32'd0, 32'd16777216, 32'd2 -> grants 0,1,2,3,0,...; responses in order: 32'hBF800000 id0, 32'h00000000 id1, 32'h4B800000 id2, 32'h40000000 id3.
3. Back-pressure: resp_ready=0, requester 1 continuously valid -> exactly 8 accepts, then req_ready stays 0 and head id/data stay stable. Set resp_ready=1 -> 8 responses drain in order and issuing resumes.
4. Reset mid-flight: issue two ops in cycles 0-1, assert reset in cycle 2 for one cycle -> resp_valid, req_ready, busy drop to 0 immediately, and no response for either op ever appears.
5. Fairness: req_valid[0] held high, req_valid[2] rises -> requester 2 granted within N_REQ issue slots, and no requester is granted twice before it.
6. Throughput: single requester continuous, resp_ready=1, FIFO_DEPTH=8 -> one issue per cycle sustained, no req_ready gap after the first accept.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: datapath width, converter latency and the
// response entry carried from the shared int-to-float converter to consumers.
package fpu_pkg;

   localparam int FP_W       = 32;
   localparam int ITOF_LAT   = 3;
   localparam int ITOF_N_REQ = 4;
   localparam int ITOF_IDW   = $clog2(ITOF_N_REQ);

   typedef struct packed {
      logic [ITOF_IDW-1:0] id;
      logic [FP_W-1:0]     data;
   } itof_resp_t;

   // Round-robin successor of index g among n slots.
   function automatic int rr_next(input int g, input int n);
      return (g + 1 == n) ? 0 : g + 1;
   endfunction

endpackage

// File: rtl/itof_resp_fifo.sv
// Show-ahead synchronous FIFO with occupancy output; head reads as zero when empty.
module itof_resp_fifo #(
   parameter int W     = 34,
   parameter int DEPTH = 8,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_i,
   input  logic [W-1:0]  din_i,
   input  logic          pop_i,
   output logic [W-1:0]  dout_o,
   output logic [CW-1:0] count_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          pop_eff;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign pop_eff = pop_i && (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop_eff) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push_i, pop_eff})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Head only moves on pop, and credits keep the writer off it, so it is stable under back-pressure.
   assign dout_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign count_o = count_q;

endmodule

// File: rtl/itof_share_arb.sv
// Round-robin front end sharing one fixed-latency int-to-float converter among
// N_REQ requesters; results are tagged by requester and queued under credit control.
module itof_share_arb
   import fpu_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int LAT        = ITOF_LAT,
   parameter int FIFO_DEPTH = 8,
   parameter int IDW        = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [FP_W*N_REQ-1:0] req_op,
   output logic [N_REQ-1:0]      req_ready,
   output logic [FP_W-1:0]       conv_op,
   input  logic [FP_W-1:0]       conv_result,
   output logic                  resp_valid,
   output logic [IDW-1:0]        resp_id,
   output logic [FP_W-1:0]       resp_data,
   input  logic                  resp_ready,
   output logic                  busy
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int FW = $clog2(LAT + 1);
   localparam int OW = CW + 1;

   logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [FP_W-1:0] op_arr  [N_REQ];
   logic [IDW-1:0]  rot_idx [N_REQ];
   logic [IDW-1:0]  grant_idx;
   logic            grant_any;
   logic            issue_ok, issue, push, pop;
   logic [LAT-1:0]  tag_v_q;
   logic [IDW-1:0]  tag_id_q [LAT];
   logic [FW-1:0]   inflight_q, inflight_d;
   logic [CW-1:0]   fifo_count;
   itof_resp_t      push_entry, head_entry;

   // Candidate order for the search: rr_ptr, rr_ptr+1, ... wrapping at N_REQ.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      logic [IDW:0] rot_sum;
      assign op_arr[gi]    = req_op[FP_W*gi +: FP_W];
      assign rot_sum       = {1'b0, rr_ptr_q} + (IDW+1)'(gi);
      assign rot_idx[gi]   = (rot_sum >= (IDW+1)'(N_REQ)) ? IDW'(rot_sum - (IDW+1)'(N_REQ))
                                                          : rot_sum[IDW-1:0];
      assign req_ready[gi] = issue && (grant_idx == IDW'(gi));
   end

   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!grant_any && req_valid[rot_idx[k]]) begin
            grant_any = 1'b1;
            grant_idx = rot_idx[k];
         end
      end
   end

   // Every issued op owns a FIFO slot from issue until it is popped.
   assign issue_ok = ({1'b0, fifo_count} + OW'(inflight_q)) < OW'(FIFO_DEPTH);
   assign issue    = issue_ok && grant_any && !reset;
   assign conv_op  = issue ? op_arr[grant_idx] : '0;
   assign rr_ptr_d = issue ? IDW'(rr_next(int'(grant_idx), N_REQ)) : rr_ptr_q;

   assign push            = tag_v_q[LAT-1];
   assign push_entry.id   = ITOF_IDW'(tag_id_q[LAT-1]);
   assign push_entry.data = conv_result;

   always_comb begin
      inflight_d = inflight_q;
      case ({issue, push})
         2'b10:   inflight_d = inflight_q + 1'b1;
         2'b01:   inflight_d = inflight_q - 1'b1;
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr_q   <= '0;
         inflight_q <= '0;
         tag_v_q    <= '0;
         for (int k = 0; k < LAT; k++) begin
            tag_id_q[k] <= '0;
         end
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         inflight_q  <= inflight_d;
         tag_v_q[0]  <= issue;
         tag_id_q[0] <= grant_idx;
         for (int k = 1; k < LAT; k++) begin
            tag_v_q[k]  <= tag_v_q[k-1];
            tag_id_q[k] <= tag_id_q[k-1];
         end
      end
   end

   itof_resp_fifo #(
      .W     ($bits(itof_resp_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .din_i   (push_entry),
      .pop_i   (pop),
      .dout_o  (head_entry),
      .count_o (fifo_count)
   );

   assign resp_valid = (fifo_count != '0);
   assign pop        = resp_valid && resp_ready;
   assign resp_id    = IDW'(head_entry.id);
   assign resp_data  = head_entry.data;
   assign busy       = (inflight_q != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_itof_share_arb.sv
// Directed bench for itof_share_arb with a behavioural 3-cycle int-to-float converter.
module tb_itof_share_arb;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   req_valid;
   logic [127:0] req_op;
   logic [3:0]   req_ready;
   logic [31:0]  conv_op;
   logic [31:0]  conv_result;
   logic         resp_valid;
   logic [1:0]   resp_id;
   logic [31:0]  resp_data;
   logic         resp_ready;
   logic         busy;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] ops_t2 [4] = '{32'hFFFFFFFF, 32'd0, 32'h01000000, 32'd2};
   logic [31:0] exp_t2 [4] = '{32'hBF800000, 32'h00000000, 32'h4B800000, 32'h40000000};
   logic [31:0] exp_t3 [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
   logic [3:0]  exp_t5 [6] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100};
   logic [31:0] cv_pipe [3] = '{32'd0, 32'd0, 32'd0};

   always #5 clk = ~clk;

   itof_share_arb dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_op      (req_op),
      .req_ready   (req_ready),
      .conv_op     (conv_op),
      .conv_result (conv_result),
      .resp_valid  (resp_valid),
      .resp_id     (resp_id),
      .resp_data   (resp_data),
      .resp_ready  (resp_ready),
      .busy        (busy)
   );

   function automatic logic [31:0] i2f(input logic [31:0] x);
      logic        s;
      logic [31:0] a, m;
      int          p;
      logic [7:0]  e;
      logic [22:0] f;
      logic        rnd;
      if (x == 32'd0) return 32'd0;
      s = x[31];
      a = s ? (~x + 32'd1) : x;
      p = 0;
      for (int i = 0; i < 32; i++) if (a[i]) p = i;
      m   = a << (31 - p);
      e   = 8'(127 + p);
      f   = m[30:8];
      rnd = m[7] & ((|m[6:0]) | f[0]);
      return {s, e, f} + 32'(rnd);
   endfunction

   always @(posedge clk) begin
      cv_pipe[0] <= i2f(conv_op);
      cv_pipe[1] <= cv_pipe[0];
      cv_pipe[2] <= cv_pipe[1];
   end
   assign conv_result = cv_pipe[2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [31:0] v);
      req_op[32*i +: 32] = v;
   endtask

   task automatic drain(input string tag);
      req_valid  = 4'b0000;
      resp_ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         nxt();
         #1;
         if (!busy) break;
      end
      chk(tag, 32'(busy), 32'd0);
   endtask

   // No push may ever land on a full FIFO.
   always @(negedge clk) begin
      if (reset === 1'b0 && dut.push === 1'b1) begin
         n_assert++;
         assert (dut.fifo_count != 4'd8)
         else begin
            n_fail++;
            $error("FAIL overflow: observed count %0d expected below 8", dut.fifo_count);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset      = 1'b1;
      req_valid  = 4'b1111;
      req_op     = '0;
      resp_ready = 1'b0;
      #2;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_valid", 32'(resp_valid), 32'd0);
      chk("rst_id", 32'(resp_id), 32'd0);
      chk("rst_data", resp_data, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_convop", conv_op, 32'd0);
      nxt();
      reset     = 1'b0;
      req_valid = 4'b0000;
      #1;
      chk("rst_rel_valid", 32'(resp_valid), 32'd0);

      // Single request
      nxt();
      req_valid  = 4'b0001;
      set_op(0, 32'd1);
      resp_ready = 1'b1;
      #1;
      chk("t1_ready_c0", 32'(req_ready), 32'b0001);
      chk("t1_convop_c0", conv_op, 32'd1);
      chk("t1_busy_c0", 32'(busy), 32'd0);
      for (int c = 1; c <= 5; c++) begin
         nxt();
         req_valid = 4'b0000;
         #1;
         chk($sformatf("t1_ready_c%0d", c), 32'(req_ready), 32'd0);
         chk($sformatf("t1_valid_c%0d", c), 32'(resp_valid), (c == 4) ? 32'd1 : 32'd0);
         chk($sformatf("t1_busy_c%0d", c), 32'(busy), (c <= 4) ? 32'd1 : 32'd0);
         if (c == 4) begin
            chk("t1_id", 32'(resp_id), 32'd0);
            chk("t1_data", resp_data, 32'h3F800000);
         end
      end

      // Re-centre the round-robin pointer at 0
      nxt();
      reset = 1'b1;
      #1;
      chk("rst2_busy", 32'(busy), 32'd0);
      nxt();
      reset = 1'b0;

      // All four requesters continuously valid
      for (int i = 0; i < 4; i++) set_op(i, ops_t2[i]);
      for (int c = 0; c < 12; c++) begin
         nxt();
         req_valid  = (c < 8) ? 4'b1111 : 4'b0000;
         resp_ready = 1'b1;
         #1;
         if (c < 8) begin
            chk($sformatf("t2_ready_c%0d", c), 32'(req_ready), 32'd1 << (c % 4));
            chk($sformatf("t2_convop_c%0d", c), conv_op, ops_t2[c % 4]);
         end else begin
            chk($sformatf("t2_ready_c%0d", c), 32'(req_ready), 32'd0);
         end
         if (c >= 4) begin
            chk($sformatf("t2_valid_c%0d", c), 32'(resp_valid), 32'd1);
            chk($sformatf("t2_id_c%0d", c), 32'(resp_id), 32'((c - 4) % 4));
            chk($sformatf("t2_data_c%0d", c), resp_data, exp_t2[(c - 4) % 4]);
         end
      end
      drain("t2_drain");

      // Back-pressure on requester 1
      for (int c = 0; c < 16; c++) begin
         nxt();
         set_op(1, 32'(c + 1));
         req_valid  = 4'b0010;
         resp_ready = 1'b0;
         #1;
         chk($sformatf("t3_ready_c%0d", c), 32'(req_ready), (c < 8) ? 32'b0010 : 32'd0);
         if (c >= 4) begin
            chk($sformatf("t3_hold_valid_c%0d", c), 32'(resp_valid), 32'd1);
            chk($sformatf("t3_hold_id_c%0d", c), 32'(resp_id), 32'd1);
            chk($sformatf("t3_hold_data_c%0d", c), resp_data, 32'h3F800000);
         end
      end
      for (int c = 16; c < 24; c++) begin
         nxt();
         set_op(1, 32'd9);
         req_valid  = 4'b0010;
         resp_ready = 1'b1;
         #1;
         chk($sformatf("t3_ready_c%0d", c), 32'(req_ready), (c == 16) ? 32'd0 : 32'b0010);
         chk($sformatf("t3_valid_c%0d", c), 32'(resp_valid), 32'd1);
         chk($sformatf("t3_id_c%0d", c), 32'(resp_id), 32'd1);
         chk($sformatf("t3_data_c%0d", c), resp_data, exp_t3[c - 16]);
      end
      nxt();
      req_valid = 4'b0000;
      #1;
      chk("t3_resume_valid", 32'(resp_valid), 32'd1);
      chk("t3_resume_data", resp_data, 32'h41100000);
      drain("t3_drain");

      // Reset mid-flight
      nxt();
      req_valid = 4'b0001;
      set_op(0, 32'd5);
      #1;
      chk("t4_ready_c0", 32'(req_ready), 32'b0001);
      nxt();
      req_valid = 4'b0010;
      set_op(1, 32'd6);
      #1;
      chk("t4_ready_c1", 32'(req_ready), 32'b0010);
      chk("t4_busy_c1", 32'(busy), 32'd1);
      nxt();
      reset     = 1'b1;
      req_valid = 4'b0001;
      #1;
      chk("t4_rst_ready", 32'(req_ready), 32'd0);
      chk("t4_rst_valid", 32'(resp_valid), 32'd0);
      chk("t4_rst_busy", 32'(busy), 32'd0);
      nxt();
      reset      = 1'b0;
      req_valid  = 4'b0000;
      resp_ready = 1'b1;
      for (int c = 3; c < 11; c++) begin
         #1;
         chk($sformatf("t4_valid_c%0d", c), 32'(resp_valid), 32'd0);
         chk($sformatf("t4_busy_c%0d", c), 32'(busy), 32'd0);
         nxt();
      end

      // Fairness: requester 0 held, requester 2 rises
      for (int c = 0; c < 6; c++) begin
         req_valid = (c == 0) ? 4'b0001 : 4'b0101;
         set_op(0, 32'd3);
         set_op(2, 32'd4);
         #1;
         chk($sformatf("t5_ready_c%0d", c), 32'(req_ready), 32'(exp_t5[c]));
         nxt();
      end
      drain("t5_drain");

      // Throughput on requester 3
      for (int c = 0; c < 20; c++) begin
         nxt();
         req_valid  = 4'b1000;
         set_op(3, 32'd2);
         resp_ready = 1'b1;
         #1;
         chk($sformatf("t6_ready_c%0d", c), 32'(req_ready), 32'b1000);
         if (c >= 4) begin
            chk($sformatf("t6_valid_c%0d", c), 32'(resp_valid), 32'd1);
            chk($sformatf("t6_id_c%0d", c), 32'(resp_id), 32'd3);
            chk($sformatf("t6_data_c%0d", c), resp_data, 32'h40000000);
         end
      end
      drain("t6_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
